hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard/stall controller for the Lapido 5-stage core; backward-acting counterpart of the forwarding path.
//  Where forwarding cannot supply a value, it stalls upstream stages and flushes downstream ones:
//  load-use, taken branch in EX, multi-cycle EX ops and memory wait.
//  Holds and flushes go to the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// PARAMETERS
//  REG_AW       4  register address width (16 GPRs)
//  MUL_LATENCY  4  total EX cycles of a multi-cycle op; valid range >=2; 1 = multicycle ignored
//  CNT_W        3  busy-counter width; must hold MUL_LATENCY-2
// PORTS
//  clock             in   1       single clock, rising edge
//  reset             in   1       synchronous, active-high
//  if_id_registerA   in   REG_AW  source A of the instruction in ID
//  if_id_registerB   in   REG_AW  source B of the instruction in ID
//  if_id_usesB       in   1       instruction in ID reads B
//  id_ex_memRead     in   1       instruction in EX is a load
//  id_ex_registerRD  in   REG_AW  destination of the instruction in EX
//  id_ex_multicycle  in   1       instruction in EX is multi-cycle
//  ex_branch_taken   in   1       branch resolved taken in EX
//  mem_req           in   1       instruction in MEM accesses memory
//  mem_ready         in   1       memory completes this cycle
//  pc_write          out  1       PC update enable
//  if_id_write       out  1       IF/ID load enable
//  if_id_flush       out  1       IF/ID <- bubble
//  id_ex_hold        out  1       ID/EX keeps its value
//  id_ex_flush       out  1       ID/EX <- bubble
//  ex_mem_hold       out  1       EX/MEM keeps its value
//  ex_mem_flush      out  1       EX/MEM <- bubble
//  mem_wb_flush      out  1       MEM/WB <- bubble
//  stall             out  1       OR of all hold and write-inhibit conditions
// BEHAVIOUR
//  - Outputs are combinational from registered state (st, busy_cnt) and the current inputs.
//  - FSM states: RUN, EX_BUSY. Reset (clocked) -> st=RUN, busy_cnt=0.
//  - While reset=1: pc_write=0, if_id_write=0; all *_flush=1; all *_hold=0; stall=0.
//  - Default (no hazard): pc_write=1, if_id_write=1; all flush=0; all hold=0; stall=0.
//  - Priority, highest first:
//    1. memwait = mem_req & ~mem_ready.
//       Drives pc_write=0, if_id_write=0, id_ex_hold=1, ex_mem_hold=1, mem_wb_flush=1, stall=1.
//       st and busy_cnt are frozen. ex_branch_taken is ignored; it stays valid because ID/EX is held.
//    2. busy = (st==RUN & id_ex_multicycle & MUL_LATENCY>1) | (st==EX_BUSY & busy_cnt!=0).
//       Drives pc_write=0, if_id_write=0, id_ex_hold=1, ex_mem_flush=1, stall=1.
//       RUN->EX_BUSY with busy_cnt<=MUL_LATENCY-2. In EX_BUSY, busy_cnt decrements.
//    3. EX_BUSY & busy_cnt==0 (release cycle): st<=RUN; id_ex_multicycle is ignored this cycle, so no re-trigger.
//       Evaluation continues at rules 4-5.
//    4. ex_branch_taken: if_id_flush=1, id_ex_flush=1, pc_write=1, if_id_write=0. This overrides load-use.
//    5. load-use = id_ex_memRead & (id_ex_registerRD==if_id_registerA | (if_id_usesB & id_ex_registerRD==if_id_registerB)).
//       Drives pc_write=0, if_id_write=0, id_ex_flush=1, stall=1.
//       Exactly one bubble: next cycle EX holds the bubble (memRead=0), so the hazard clears.
//  - Net stall of a multi-cycle op is MUL_LATENCY-1 cycles, excluding memwait cycles.
//  - R0 is not special: a load to R0 followed by a read of R0 still stalls.
//  - Reset mid-EX_BUSY aborts the op; st=RUN on the next cycle.
// CONFIGURATION
//  HAZARD_STALL_CNT_EN defined:
//    adds port stall_cycles out 16 (performance count).
//    Reset 0; +1 on each cycle with stall=1 and reset=0; saturates at 16'hFFFF.
//  HAZARD_STALL_CNT_EN undefined: port and counter are absent; other behaviour is identical.
// STRUCTURE
//  - lapido_pipe_pkg: REG_AW, hazard state encoding (RUN=1'b0, EX_BUSY=1'b1), default MUL_LATENCY.
//  - Sub-module hazard_busy_cnt: load/decrement/freeze down-counter with zero flag; everything else is flat.
// TESTING
//  1. Load R3 in EX (memRead=1, RD=3), ID reads A=3
//     -> one cycle pc_write=0, if_id_write=0, id_ex_flush=1; next cycle all default.
//  2. Same as 1 with ex_branch_taken=1 -> if_id_flush=1, id_ex_flush=1, pc_write=1; no stall.
//  3. id_ex_multicycle=1, MUL_LATENCY=4
//     -> stall=1 and ex_mem_flush=1 for exactly 3 cycles, then release; no re-trigger.
//  4. mem_req=1, mem_ready=0 for 5 cycles during EX_BUSY (busy_cnt=1)
//     -> full freeze, mem_wb_flush=1, busy_cnt stays 1; busy resumes after mem_ready=1.
//  5. reset=1 for 1 cycle mid-EX_BUSY -> outputs follow the reset rule that cycle; st=RUN after.
//  6. HAZARD_STALL_CNT_EN: run scenarios 1+3 -> stall_cycles=4.
//     Force 70000 stall cycles -> stall_cycles=16'hFFFF.

Source files
------------

// File: rtl/lapido_pipe_pkg.sv
// ----------------------------------------------------------------------------
// lapido_pipe_pkg
// Shared definitions for the Lapido 5-stage pipeline control logic.
//   DEF_REG_AW       : register address width (16 GPRs)
//   DEF_MUL_LATENCY  : default total EX cycles of a multi-cycle op
//   DEF_CNT_W        : default busy-counter width
//   hazard_state_t   : hazard controller FSM encoding (RUN / EX_BUSY)
//   busy_load_value  : value loaded into the busy counter when an op starts
// ----------------------------------------------------------------------------
package lapido_pipe_pkg;

    localparam int DEF_REG_AW      = 4;
    localparam int DEF_MUL_LATENCY = 4;
    localparam int DEF_CNT_W       = 3;

    typedef enum logic {
        RUN     = 1'b0,
        EX_BUSY = 1'b1
    } hazard_state_t;

    // The first busy cycle happens in RUN, and EX_BUSY needs one more cycle
    // to release, so the counter only has to cover the cycles in between.
    function automatic int busy_load_value(input int latency);
        return (latency >= 2) ? (latency - 2) : 0;
    endfunction

endpackage

// File: rtl/hazard_busy_cnt.sv
// ----------------------------------------------------------------------------
// hazard_busy_cnt
// Down-counter for the remaining busy cycles of a multi-cycle EX op.
// Load has priority over decrement; with neither asserted the count is frozen.
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high; clears the count
//   load        in   load load_value
//   dec         in   decrement by one
//   load_value  in   CNT_W value loaded on load
//   count       out  current count
//   zero        out  count == 0
// ----------------------------------------------------------------------------
module hazard_busy_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard/stall controller for the Lapido 5-stage core. Stalls
// upstream stages and flushes downstream ones for memory wait, multi-cycle
// EX ops, taken branches in EX and load-use hazards (in that priority).
// Optional feature macro: HAZARD_STALL_CNT_EN adds the stall_cycles
// performance counter port (saturating 16-bit count of stall cycles).
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   if_id_registerA/B, usesB     source operands of the instruction in ID
//   id_ex_memRead/registerRD     load flag and destination of the EX instr
//   id_ex_multicycle             EX instruction is multi-cycle
//   ex_branch_taken              branch resolved taken in EX
//   mem_req, mem_ready           MEM access request / completion
//   pc_write, if_id_write        PC and IF/ID load enables
//   if_id_flush, id_ex_flush,
//   ex_mem_flush, mem_wb_flush   bubble insertion per pipeline register
//   id_ex_hold, ex_mem_hold      register keeps its value
//   stall                        any hold / write-inhibit condition
//   stall_cycles                 (HAZARD_STALL_CNT_EN only) stall count
// ----------------------------------------------------------------------------
module hazard_ctrl
    import lapido_pipe_pkg::*;
#(
    parameter int REG_AW      = DEF_REG_AW,
    parameter int MUL_LATENCY = DEF_MUL_LATENCY,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] if_id_registerA,
    input  logic [REG_AW-1:0] if_id_registerB,
    input  logic              if_id_usesB,
    input  logic              id_ex_memRead,
    input  logic [REG_AW-1:0] id_ex_registerRD,
    input  logic              id_ex_multicycle,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_hold,
    output logic              id_ex_flush,
    output logic              ex_mem_hold,
    output logic              ex_mem_flush,
    output logic              mem_wb_flush,
    output logic              stall
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    // A latency of 1 means the op completes like any other, so it never busies EX.
    localparam bit MC_EN = (MUL_LATENCY > 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(busy_load_value(MUL_LATENCY));

    hazard_state_t    st;
    hazard_state_t    st_next;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] busy_cnt;
    logic             cnt_zero;

    logic memwait;
    logic busy;
    logic load_use;

    hazard_busy_cnt #(
        .CNT_W(CNT_W)
    ) u_busy_cnt (
        .clock      (clock),
        .reset      (reset),
        .load       (cnt_load),
        .dec        (cnt_dec),
        .load_value (LOAD_VAL),
        .count      (busy_cnt),
        .zero       (cnt_zero)
    );

    // R0 is deliberately not excluded: a load to R0 still stalls a reader of R0.
    assign memwait  = mem_req & ~mem_ready;
    assign busy     = ((st == RUN) & id_ex_multicycle & MC_EN) |
                      ((st == EX_BUSY) & ~cnt_zero);
    assign load_use = id_ex_memRead &
                      ((id_ex_registerRD == if_id_registerA) |
                       (if_id_usesB & (id_ex_registerRD == if_id_registerB)));

    // FSM state register; a reset in the middle of EX_BUSY abandons the op.
    always_ff @(posedge clock) begin
        if (reset) begin
            st <= RUN;
        end else begin
            st <= st_next;
        end
    end

    // Priority decode of the hazards into pipeline controls and next state.
    // Memory wait freezes everything including the FSM; the EX_BUSY release
    // cycle ignores id_ex_multicycle because the same op is still in ID/EX.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_hold   = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_hold  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        stall        = 1'b0;
        st_next      = st;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;

        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (memwait) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_hold   = 1'b1;
            ex_mem_hold  = 1'b1;
            mem_wb_flush = 1'b1;
            stall        = 1'b1;
        end else if (busy) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_hold   = 1'b1;
            ex_mem_flush = 1'b1;
            stall        = 1'b1;
            if (st == RUN) begin
                st_next  = EX_BUSY;
                cnt_load = 1'b1;
            end else begin
                cnt_dec  = 1'b1;
            end
        end else begin
            if (st == EX_BUSY) begin
                st_next = RUN;
            end
            if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if_id_write = 1'b0;
            end else if (load_use) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                stall       = 1'b1;
            end
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    // Saturating performance count of stalled cycles (stall is 0 during reset).
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles <= 16'd0;
        end else if (stall && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl: a table of directed vectors, a few
// multi-cycle sequences and a randomized run against a behavioural model.
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int ML = 4;

    // Output vector order: pc_write, if_id_write, if_id_flush, id_ex_hold,
    // id_ex_flush, ex_mem_hold, ex_mem_flush, mem_wb_flush, stall
    localparam logic [8:0] O_DEF  = 9'b1_1_0_0_0_0_0_0_0;
    localparam logic [8:0] O_RST  = 9'b0_0_1_0_1_0_1_1_0;
    localparam logic [8:0] O_LU   = 9'b0_0_0_0_1_0_0_0_1;
    localparam logic [8:0] O_BR   = 9'b1_0_1_0_1_0_0_0_0;
    localparam logic [8:0] O_MW   = 9'b0_0_0_1_0_1_0_1_1;
    localparam logic [8:0] O_BUSY = 9'b0_0_0_1_0_0_1_0_1;

    typedef struct packed {
        logic       rst;
        logic [3:0] a;
        logic [3:0] b;
        logic       ub;
        logic       mr;
        logic [3:0] rd;
        logic       mc;
        logic       br;
        logic       mq;
        logic       my;
    } in_t;

    typedef struct {
        string      name;
        in_t        stim;
        logic [8:0] exp;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] if_id_registerA;
    logic [3:0] if_id_registerB;
    logic       if_id_usesB;
    logic       id_ex_memRead;
    logic [3:0] id_ex_registerRD;
    logic       id_ex_multicycle;
    logic       ex_branch_taken;
    logic       mem_req;
    logic       mem_ready;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_hold;
    logic       id_ex_flush;
    logic       ex_mem_hold;
    logic       ex_mem_flush;
    logic       mem_wb_flush;
    logic       stall;
`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Behavioural model: whether a multi-cycle op is in flight and how many
    // non-frozen cycles it has spent in EX so far.
    bit m_in_op = 1'b0;
    int m_age   = 0;
    int m_stalls = 0;

    hazard_ctrl #(
        .REG_AW      (4),
        .MUL_LATENCY (ML),
        .CNT_W       (3)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .if_id_registerA  (if_id_registerA),
        .if_id_registerB  (if_id_registerB),
        .if_id_usesB      (if_id_usesB),
        .id_ex_memRead    (id_ex_memRead),
        .id_ex_registerRD (id_ex_registerRD),
        .id_ex_multicycle (id_ex_multicycle),
        .ex_branch_taken  (ex_branch_taken),
        .mem_req          (mem_req),
        .mem_ready        (mem_ready),
        .pc_write         (pc_write),
        .if_id_write      (if_id_write),
        .if_id_flush      (if_id_flush),
        .id_ex_hold       (id_ex_hold),
        .id_ex_flush      (id_ex_flush),
        .ex_mem_hold      (ex_mem_hold),
        .ex_mem_flush     (ex_mem_flush),
        .mem_wb_flush     (mem_wb_flush),
        .stall            (stall)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cycles     (stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    function automatic in_t mk(input logic rst, input logic [3:0] a, input logic [3:0] b,
                               input logic ub, input logic mr, input logic [3:0] rd,
                               input logic mc, input logic br, input logic mq, input logic my);
        in_t s;
        s.rst = rst; s.a = a; s.b = b; s.ub = ub; s.mr = mr; s.rd = rd;
        s.mc = mc; s.br = br; s.mq = mq; s.my = my;
        return s;
    endfunction

    function automatic logic [8:0] model_out(input in_t s);
        bit lu;
        bit busy_now;
        lu = s.mr && ((s.rd == s.a) || (s.ub && (s.rd == s.b)));
        busy_now = m_in_op ? (m_age < ML - 1) : (s.mc && (ML > 1));
        if (s.rst)               return O_RST;
        else if (s.mq && !s.my)  return O_MW;
        else if (busy_now)       return O_BUSY;
        else if (s.br)           return O_BR;
        else if (lu)             return O_LU;
        else                     return O_DEF;
    endfunction

    task automatic model_step(input in_t s);
        logic [8:0] e;
        if (s.rst) begin
            m_in_op  = 1'b0;
            m_age    = 0;
            m_stalls = 0;
        end else begin
            e = model_out(s);
            if (e[0]) m_stalls++;
            if (!(s.mq && !s.my)) begin
                if (m_in_op) begin
                    if (m_age < ML - 1) m_age++;
                    else m_in_op = 1'b0;
                end else if (s.mc && (ML > 1)) begin
                    m_in_op = 1'b1;
                    m_age   = 1;
                end
            end
        end
    endtask

    // Drives one cycle of inputs just after the falling edge so the outputs
    // can be sampled well before the next rising edge.
    task automatic applyStimulus(input in_t s);
        @(negedge clock);
        reset            = s.rst;
        if_id_registerA  = s.a;
        if_id_registerB  = s.b;
        if_id_usesB      = s.ub;
        id_ex_memRead    = s.mr;
        id_ex_registerRD = s.rd;
        id_ex_multicycle = s.mc;
        ex_branch_taken  = s.br;
        mem_req          = s.mq;
        mem_ready        = s.my;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [8:0] exp);
        logic [8:0] got;
        got = {pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_flush,
               ex_mem_hold, ex_mem_flush, mem_wb_flush, stall};
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %b required %b", name, got, exp);
    endtask

    task automatic runCycle(input string name, input in_t s, input logic [8:0] exp);
        applyStimulus(s);
        checkOutput(name, exp);
        model_step(s);
    endtask

`ifdef HAZARD_STALL_CNT_EN
    task automatic checkCount(input string name, input logic [15:0] exp);
        total_cnt++;
        if (stall_cycles === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0d required %0d", name, stall_cycles, exp);
    endtask
`endif

    initial begin
        vec_t vecs[14];
        in_t  s;

        vecs[0]  = '{"reset",          mk(1, 4'd3, 4'd3, 1, 1, 4'd3, 0, 1, 1, 0), O_RST};
        vecs[1]  = '{"idle",           mk(0, 4'd1, 4'd2, 1, 0, 4'd1, 0, 0, 0, 0), O_DEF};
        vecs[2]  = '{"loaduse_a",      mk(0, 4'd3, 4'd2, 0, 1, 4'd3, 0, 0, 0, 0), O_LU};
        vecs[3]  = '{"bubble_after",   mk(0, 4'd3, 4'd2, 0, 0, 4'd3, 0, 0, 0, 0), O_DEF};
        vecs[4]  = '{"loaduse_b",      mk(0, 4'd1, 4'd5, 1, 1, 4'd5, 0, 0, 0, 0), O_LU};
        vecs[5]  = '{"b_unused",       mk(0, 4'd1, 4'd5, 0, 1, 4'd5, 0, 0, 0, 0), O_DEF};
        vecs[6]  = '{"load_nomatch",   mk(0, 4'd1, 4'd2, 1, 1, 4'd6, 0, 0, 0, 0), O_DEF};
        vecs[7]  = '{"loaduse_r0",     mk(0, 4'd0, 4'd7, 0, 1, 4'd0, 0, 0, 0, 0), O_LU};
        vecs[8]  = '{"branch_over_lu", mk(0, 4'd3, 4'd2, 0, 1, 4'd3, 0, 1, 0, 0), O_BR};
        vecs[9]  = '{"branch",         mk(0, 4'd1, 4'd2, 1, 0, 4'd9, 0, 1, 0, 0), O_BR};
        vecs[10] = '{"memwait_top",    mk(0, 4'd3, 4'd2, 0, 1, 4'd3, 0, 1, 1, 0), O_MW};
        vecs[11] = '{"mem_ready_lu",   mk(0, 4'd3, 4'd2, 0, 1, 4'd3, 0, 0, 1, 1), O_LU};
        vecs[12] = '{"reset_again",    mk(1, 4'd3, 4'd2, 0, 1, 4'd3, 0, 0, 0, 0), O_RST};
        vecs[13] = '{"idle_after_rst", mk(0, 4'd1, 4'd2, 0, 0, 4'd3, 0, 0, 0, 0), O_DEF};

        $display("[TB] directed vector table");
        for (int i = 0; i < 14; i++) begin
            runCycle(vecs[i].name, vecs[i].stim, vecs[i].exp);
        end

        $display("[TB] multi-cycle op, latency %0d", ML);
        runCycle("mc_busy1",   mk(0, 4'd1, 4'd2, 0, 0, 4'd3, 1, 0, 0, 0), O_BUSY);
        runCycle("mc_busy2",   mk(0, 4'd1, 4'd2, 0, 0, 4'd3, 1, 0, 0, 0), O_BUSY);
        runCycle("mc_busy3",   mk(0, 4'd1, 4'd2, 0, 0, 4'd3, 1, 0, 0, 0), O_BUSY);
        runCycle("mc_release", mk(0, 4'd1, 4'd2, 0, 0, 4'd3, 1, 0, 0, 0), O_DEF);
        runCycle("mc_after",   mk(0, 4'd1, 4'd2, 0, 0, 4'd3, 0, 0, 0, 0), O_DEF);

        $display("[TB] memory wait during EX_BUSY");
        runCycle("mw_busy1", mk(0, 4'd1, 4'd2, 0, 0, 4'd3, 1, 0, 0, 0), O_BUSY);
        runCycle("mw_busy2", mk(0, 4'd1, 4'd2, 0, 0, 4'd3, 1, 0, 0, 0), O_BUSY);
        for (int i = 0; i < 5; i++) begin
            runCycle("mw_freeze", mk(0, 4'd1, 4'd2, 0, 0, 4'd3, 1, 1, 1, 0), O_MW);
        end
        runCycle("mw_resume",  mk(0, 4'd1, 4'd2, 0, 0, 4'd3, 1, 0, 1, 1), O_BUSY);
        runCycle("mw_release", mk(0, 4'd1, 4'd2, 0, 0, 4'd3, 1, 0, 0, 0), O_DEF);
        runCycle("mw_after",   mk(0, 4'd1, 4'd2, 0, 0, 4'd3, 0, 0, 0, 0), O_DEF);

        $display("[TB] reset in the middle of EX_BUSY");
        runCycle("rb_busy1", mk(0, 4'd1, 4'd2, 0, 0, 4'd3, 1, 0, 0, 0), O_BUSY);
        runCycle("rb_busy2", mk(0, 4'd1, 4'd2, 0, 0, 4'd3, 1, 0, 0, 0), O_BUSY);
        runCycle("rb_reset", mk(1, 4'd1, 4'd2, 0, 0, 4'd3, 1, 0, 0, 0), O_RST);
        runCycle("rb_run",   mk(0, 4'd1, 4'd2, 0, 0, 4'd3, 0, 0, 0, 0), O_DEF);

        $display("[TB] randomized run against the model");
        runCycle("rand_reset", mk(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 0), O_RST);
        for (int i = 0; i < 400; i++) begin
            s.rst = ($urandom_range(0, 39) == 0);
            s.a   = 4'($urandom_range(0, 3));
            s.b   = 4'($urandom_range(0, 3));
            s.ub  = 1'($urandom_range(0, 1));
            s.mr  = 1'($urandom_range(0, 1));
            s.rd  = 4'($urandom_range(0, 3));
            s.mc  = ($urandom_range(0, 3) == 0);
            s.br  = ($urandom_range(0, 4) == 0);
            s.mq  = ($urandom_range(0, 3) == 0);
            s.my  = 1'($urandom_range(0, 1));
            runCycle("random", s, model_out(s));
        end
`ifdef HAZARD_STALL_CNT_EN
        @(negedge clock);
        checkCount("rand_stall_cycles", 16'((m_stalls > 65535) ? 65535 : m_stalls));

        $display("[TB] stall counter");
        runCycle("sc_reset",  mk(1, 4'd0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 0), O_RST);
        runCycle("sc_lu",     mk(0, 4'd3, 4'd2, 0, 1, 4'd3, 0, 0, 0, 0), O_LU);
        runCycle("sc_bubble", mk(0, 4'd3, 4'd2, 0, 0, 4'd3, 0, 0, 0, 0), O_DEF);
        runCycle("sc_busy1",  mk(0, 4'd1, 4'd2, 0, 0, 4'd5, 1, 0, 0, 0), O_BUSY);
        runCycle("sc_busy2",  mk(0, 4'd1, 4'd2, 0, 0, 4'd5, 1, 0, 0, 0), O_BUSY);
        runCycle("sc_busy3",  mk(0, 4'd1, 4'd2, 0, 0, 4'd5, 1, 0, 0, 0), O_BUSY);
        runCycle("sc_rel",    mk(0, 4'd1, 4'd2, 0, 0, 4'd5, 1, 0, 0, 0), O_DEF);
        @(negedge clock);
        checkCount("stall_cycles_4", 16'd4);
        applyStimulus(mk(0, 4'd1, 4'd2, 0, 0, 4'd5, 0, 0, 1, 0));
        repeat (70000) @(posedge clock);
        @(negedge clock);
        checkCount("stall_cycles_sat", 16'hFFFF);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
